// File: rtl/mram_controller.sv
// Synchronous initiator for a 16-bit asynchronous MRAM part.
// A single-cycle req/ack host handshake is turned into sequenced E_n / G_n / W_n
// strobes with programmable setup, write-pulse, hold and read-access cycle counts.
//
// Ports:
//   SIM_CLK, SIM_RST             clock, asynchronous active-high reset
//   req, we, addr, wdata, be     host request (sampled only while idle)
//   busy, ack, rdata             host status / completion / read data
//   mem_a, mem_e_n, mem_g_n,     MRAM address and active-low strobes
//   mem_w_n, mem_lb_n, mem_ub_n
//   mem_dq_out, mem_dq_oe        write data and board-level DQ drive enable
//   mem_dq_in                    DQ as seen on the board
module mram_controller #(
  parameter int unsigned T_SU = 2,
  parameter int unsigned T_WP = 3,
  parameter int unsigned T_HD = 1,
  parameter int unsigned T_RD = 3
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  be,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic [15:0] mem_a,
  output logic        mem_e_n,
  output logic        mem_g_n,
  output logic        mem_w_n,
  output logic        mem_lb_n,
  output logic        mem_ub_n,
  output logic [15:0] mem_dq_out,
  output logic        mem_dq_oe,
  input  logic [15:0] mem_dq_in
);

  if (T_SU < 1 || T_SU > 15) begin : g_bad_su
    $error("T_SU out of range 1..15");
  end
  if (T_WP < 1 || T_WP > 15) begin : g_bad_wp
    $error("T_WP out of range 1..15");
  end
  if (T_HD < 1 || T_HD > 15) begin : g_bad_hd
    $error("T_HD out of range 1..15");
  end
  if (T_RD < 1 || T_RD > 15) begin : g_bad_rd
    $error("T_RD out of range 1..15");
  end

  localparam logic [3:0] SuLoad = 4'(T_SU - 1);
  localparam logic [3:0] WpLoad = 4'(T_WP - 1);
  localparam logic [3:0] HdLoad = 4'(T_HD - 1);
  localparam logic [3:0] RdLoad = 4'(T_RD - 1);

  typedef enum logic [2:0] {
    StIdle, StWsu, StWp, StWhd, StRsu, StRd, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] rdata_q, rdata_d;

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state: every timed state is loaded with (count-1) on entry and exits at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = SuLoad;
          state_d = we ? StWsu : StRsu;
        end
      end
      StWsu: begin
        if (cnt_q == 4'd0) begin
          state_d = StWp;
          cnt_d   = WpLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWp: begin
        if (cnt_q == 4'd0) begin
          state_d = StWhd;
          cnt_d   = HdLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWhd: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRsu: begin
        if (cnt_q == 4'd0) begin
          state_d = StRd;
          cnt_d   = RdLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRd: begin
        if (cnt_q == 4'd0) begin
          // Deselected lanes keep their previous contents.
          if (be_q[0]) rdata_d[7:0]  = mem_dq_in[7:0];
          if (be_q[1]) rdata_d[15:8] = mem_dq_in[15:8];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode from state only; IDLE and DONE are the bus turnaround cycles.
  always_comb begin
    mem_e_n   = 1'b1;
    mem_g_n   = 1'b1;
    mem_w_n   = 1'b1;
    mem_lb_n  = 1'b1;
    mem_ub_n  = 1'b1;
    mem_dq_oe = 1'b0;
    case (state_q)
      StWsu, StWhd: begin
        mem_e_n   = 1'b0;
        mem_dq_oe = 1'b1;
        mem_lb_n  = ~be_q[0];
        mem_ub_n  = ~be_q[1];
      end
      StWp: begin
        mem_e_n   = 1'b0;
        mem_w_n   = 1'b0;
        mem_dq_oe = 1'b1;
        mem_lb_n  = ~be_q[0];
        mem_ub_n  = ~be_q[1];
      end
      StRsu: begin
        mem_e_n  = 1'b0;
        mem_lb_n = ~be_q[0];
        mem_ub_n = ~be_q[1];
      end
      StRd: begin
        mem_e_n  = 1'b0;
        mem_g_n  = 1'b0;
        mem_lb_n = ~be_q[0];
        mem_ub_n = ~be_q[1];
      end
      default: ;
    endcase
  end

  assign mem_a      = addr_q;
  assign mem_dq_out = wdata_q;
  assign busy       = (state_q != StIdle);
  assign ack        = (state_q == StDone);
  assign rdata      = rdata_q;

  a_no_g_and_w: assert property (@(posedge SIM_CLK) disable iff (SIM_RST)
    !(!mem_g_n && !mem_w_n));
  a_no_oe_while_g: assert property (@(posedge SIM_CLK) disable iff (SIM_RST)
    !(mem_dq_oe && !mem_g_n));
  a_w_needs_e: assert property (@(posedge SIM_CLK) disable iff (SIM_RST)
    !mem_w_n |-> !mem_e_n);
  a_stable_in_wp: assert property (@(posedge SIM_CLK) disable iff (SIM_RST)
    !mem_w_n |=> (mem_w_n || ($stable(mem_a) && $stable(mem_dq_out))));

endmodule

// File: tb/tb_mram_controller.sv
// Directed bench for mram_controller: one instance with default timing and one with
// all cycle counts at 1, each talking to a small behavioural MRAM model.
module tb_mram_controller;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;
  always #5 SIM_CLK = ~SIM_CLK;

  // Default-timing instance.
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0;
  logic [1:0]  be0 = '0;
  logic        busy0, ack0, e_n0, g_n0, w_n0, lb_n0, ub_n0, oe0;
  logic [15:0] rdata0, a0, dq_out0;
  logic [15:0] dq_in0 = 16'hDEAD;

  // All-ones timing instance.
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr1 = '0, wdata1 = '0;
  logic [1:0]  be1 = '0;
  logic        busy1, ack1, e_n1, g_n1, w_n1, lb_n1, ub_n1, oe1;
  logic [15:0] rdata1, a1, dq_out1;
  logic [15:0] dq_in1 = 16'hDEAD;

  mram_controller dut0 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .be(be0), .busy(busy0), .ack(ack0), .rdata(rdata0), .mem_a(a0),
    .mem_e_n(e_n0), .mem_g_n(g_n0), .mem_w_n(w_n0), .mem_lb_n(lb_n0), .mem_ub_n(ub_n0),
    .mem_dq_out(dq_out0), .mem_dq_oe(oe0), .mem_dq_in(dq_in0)
  );

  mram_controller #(.T_SU(1), .T_WP(1), .T_HD(1), .T_RD(1)) dut1 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .req(req1), .we(we1), .addr(addr1),
    .wdata(wdata1), .be(be1), .busy(busy1), .ack(ack1), .rdata(rdata1), .mem_a(a1),
    .mem_e_n(e_n1), .mem_g_n(g_n1), .mem_w_n(w_n1), .mem_lb_n(lb_n1), .mem_ub_n(ub_n1),
    .mem_dq_out(dq_out1), .mem_dq_oe(oe1), .mem_dq_in(dq_in1)
  );

  // MRAM models: byte-lane writes while W_n is low, reads presented on the falling edge.
  logic [15:0] mem0 [logic [15:0]];
  logic [15:0] mem1 [logic [15:0]];

  always @(posedge SIM_CLK) begin
    if (!SIM_RST && !e_n0 && !w_n0 && oe0) begin
      logic [15:0] v;
      v = mem0.exists(a0) ? mem0[a0] : 16'h0000;
      if (!lb_n0) v[7:0] = dq_out0[7:0];
      if (!ub_n0) v[15:8] = dq_out0[15:8];
      mem0[a0] = v;
    end
    if (!SIM_RST && !e_n1 && !w_n1 && oe1) begin
      logic [15:0] v;
      v = mem1.exists(a1) ? mem1[a1] : 16'h0000;
      if (!lb_n1) v[7:0] = dq_out1[7:0];
      if (!ub_n1) v[15:8] = dq_out1[15:8];
      mem1[a1] = v;
    end
  end

  always @(negedge SIM_CLK) begin
    if (!e_n0 && !g_n0) dq_in0 <= mem0.exists(a0) ? mem0[a0] : 16'h0000;
    else dq_in0 <= 16'hDEAD;
    if (!e_n1 && !g_n1) dq_in1 <= mem1.exists(a1) ? mem1[a1] : 16'h0000;
    else dq_in1 <= 16'hDEAD;
  end

  // Waveform monitor on instance 0 (cumulative counters; tests take deltas).
  int wlow_cnt = 0, glow_cnt = 0, stab_viol = 0, goe_viol = 0, ack_cnt = 0, ack1_cnt = 0;
  logic        prev_wlow = 1'b0;
  logic [15:0] prev_a = '0, prev_dq = '0;

  always @(negedge SIM_CLK) begin
    if (!w_n0) wlow_cnt <= wlow_cnt + 1;
    if (!g_n0) glow_cnt <= glow_cnt + 1;
    if ((!g_n0 && oe0) || (!g_n0 && !w_n0)) goe_viol <= goe_viol + 1;
    if (!w_n0 && prev_wlow && (a0 != prev_a || dq_out0 != prev_dq)) stab_viol <= stab_viol + 1;
    if (ack0) ack_cnt <= ack_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
    prev_wlow <= !w_n0;
    prev_a    <= a0;
    prev_dq   <= dq_out0;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access on instance 0; lat = cycles from req cycle to ack cycle (50 = timed out).
  task automatic access0(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] b, output int lat);
    @(posedge SIM_CLK); #1;
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
    @(posedge SIM_CLK); #1;
    req0 = 1'b0;
    lat = 1;
    while (!ack0 && lat < 50) begin
      @(posedge SIM_CLK); #1;
      lat++;
    end
  endtask

  task automatic access1(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] b, output int lat);
    @(posedge SIM_CLK); #1;
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
    @(posedge SIM_CLK); #1;
    req1 = 1'b0;
    lat = 1;
    while (!ack1 && lat < 50) begin
      @(posedge SIM_CLK); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, snap_w, snap_g, snap_a, n;

    // Reset values.
    #2;
    check_eq("rst_e_n", e_n0, 1'b1);
    check_eq("rst_strobes", {g_n0, w_n0, lb_n0, ub_n0}, 4'hF);
    check_eq("rst_oe_busy_ack", {oe0, busy0, ack0}, 3'b000);
    check_eq("rst_a_dq_rdata", {a0, dq_out0, rdata0}, 48'h0);
    repeat (2) @(posedge SIM_CLK);
    #1 SIM_RST = 1'b0;

    // Write then read with default timing.
    snap_w = wlow_cnt; snap_g = glow_cnt;
    access0(1'b1, 16'h0123, 16'hBEEF, 2'b11, lat);
    check_eq("wr_latency", lat, 7);
    check_eq("wr_wlow_cycles", wlow_cnt - snap_w, 3);
    check_eq("wr_g_high", glow_cnt - snap_g, 0);
    access0(1'b0, 16'h0123, 16'h0000, 2'b11, lat);
    check_eq("rd_latency", lat, 6);
    check_eq("rd_data", rdata0, 16'hBEEF);

    // Byte lanes.
    access0(1'b1, 16'h0040, 16'h1234, 2'b11, lat);
    access0(1'b1, 16'h0040, 16'hAB00, 2'b10, lat);
    access0(1'b0, 16'h0040, 16'h0000, 2'b11, lat);
    check_eq("lane_merge", rdata0, 16'hAB34);
    // Read of upper lane only keeps lower rdata lane (prior 0x34).
    access0(1'b0, 16'h0123, 16'h0000, 2'b10, lat);
    check_eq("lane_read_hold", rdata0, 16'hBE34);
    // be=00 still runs and acks.
    access0(1'b1, 16'h0123, 16'h0000, 2'b00, lat);
    check_eq("be0_wr_latency", lat, 7);
    access0(1'b0, 16'h0123, 16'h0000, 2'b11, lat);
    check_eq("be0_no_write", rdata0, 16'hBEEF);

    // Back-to-back with req held high.
    @(posedge SIM_CLK); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'h0005; be0 = 2'b11;
    lat = 0;
    do begin
      @(posedge SIM_CLK); #1;
      lat++;
    end while (!ack0 && lat < 50);
    check_eq("b2b_wr_latency", lat, 7);
    check_eq("b2b_done_oe", oe0, 1'b0);
    we0 = 1'b0;
    @(posedge SIM_CLK); #1;
    check_eq("b2b_idle_gap", {busy0, oe0, g_n0}, 3'b001);
    @(posedge SIM_CLK); #1;
    check_eq("b2b_rd_accepted", busy0, 1'b1);
    req0 = 1'b0;
    lat = 1;
    while (!ack0 && lat < 50) begin
      @(posedge SIM_CLK); #1;
      lat++;
    end
    check_eq("b2b_rd_latency", lat, 6);
    check_eq("b2b_rd_data", rdata0, 16'h0005);

    // Reset in the middle of the write pulse.
    @(posedge SIM_CLK); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0200; wdata0 = 16'h5555; be0 = 2'b11;
    @(posedge SIM_CLK); #1;
    req0 = 1'b0;
    n = 0;
    while (w_n0 && n < 20) begin
      @(posedge SIM_CLK); #1;
      n++;
    end
    check_eq("mid_wp_reached", w_n0, 1'b0);
    snap_a = ack_cnt;
    SIM_RST = 1'b1;
    #1;
    check_eq("mid_rst_strobes", {w_n0, e_n0, oe0}, 3'b110);
    check_eq("mid_rst_busy_ack", {busy0, ack0}, 2'b00);
    check_eq("mid_rst_rdata", rdata0, 16'h0000);
    @(posedge SIM_CLK); #1;
    SIM_RST = 1'b0;
    repeat (8) @(posedge SIM_CLK);
    #1;
    check_eq("mid_rst_no_ack", ack_cnt - snap_a, 0);
    access0(1'b0, 16'h0000, 16'h0000, 2'b11, lat);
    check_eq("post_rst_rd_latency", lat, 6);
    check_eq("post_rst_rd_data", rdata0, 16'h0000);

    // All timing parameters at 1, with a req raised while busy.
    snap_a = ack1_cnt;
    @(posedge SIM_CLK); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h07FF; wdata1 = 16'hFFFF; be1 = 2'b11;
    @(posedge SIM_CLK); #1;
    check_eq("p1_busy", busy1, 1'b1);
    we1 = 1'b0; addr1 = 16'h0000;
    lat = 1;
    @(posedge SIM_CLK); #1;
    req1 = 1'b0;
    lat++;
    while (!ack1 && lat < 50) begin
      @(posedge SIM_CLK); #1;
      lat++;
    end
    check_eq("p1_wr_latency", lat, 4);
    repeat (6) @(posedge SIM_CLK);
    #1;
    check_eq("p1_single_ack", ack1_cnt - snap_a, 1);
    access1(1'b0, 16'h07FF, 16'h0000, 2'b11, lat);
    check_eq("p1_rd_latency", lat, 3);
    check_eq("p1_rd_data", rdata1, 16'hFFFF);

    // Global waveform invariants on instance 0.
    check_eq("inv_g_oe_w", goe_viol, 0);
    check_eq("inv_wp_stable", stab_viol, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mram_controller.md
Name: mram_controller

Overview:
- Synchronous initiator for the 16-bit asynchronous MRAM part interface (E_n, G_n, W_n, LB_n/UB_n, A[15:0], DQ[15:0]).
- Converts a single-cycle host request/acknowledge handshake into correctly sequenced chip-enable, output-enable and write-strobe waveforms, with programmable cycle counts.
- Sits between the AGC memory-bus logic and the MRAM devices on the simulated board.
- DQ tristating is done at board level from mem_dq_out/mem_dq_oe.

Parameters:
- T_SU, 2, cycles that address, data and E_n are stable before W_n falls (write) or before G_n falls (read); range 1..15.
- T_WP, 3, cycles W_n is held low; range 1..15.
- T_HD, 1, cycles that data and address are held after W_n rises; range 1..15.
- T_RD, 3, cycles from G_n low to the rdata sample; range 1..15.

Ports:
- SIM_CLK  input  1  system clock; all state changes on the rising edge.
- SIM_RST  input  1  asynchronous reset, active-high.
- req  input  1  host request; sampled only in IDLE.
- we  input  1  1=write, 0=read; sampled with req.
- addr  input  16  word address; sampled with req.
- wdata  input  16  write data; sampled with req.
- be  input  2  byte enables, [0]=lower, [1]=upper, active-high; sampled with req.
- busy  output  1  high in every state except IDLE.
- ack  output  1  one-cycle completion pulse.
- rdata  output  16  read data; valid when ack is high after a read, held until the next read's ack.
- mem_a  output  16  MRAM address pins.
- mem_e_n  output  1  chip enable, active-low.
- mem_g_n  output  1  output enable, active-low.
- mem_w_n  output  1  write enable, active-low.
- mem_lb_n  output  1  lower-byte select, active-low.
- mem_ub_n  output  1  upper-byte select, active-low.
- mem_dq_out  output  16  data driven toward MRAM.
- mem_dq_oe  output  1  1 = board drives mem_dq_out onto DQ.
- mem_dq_in  input  16  DQ as seen on the board.

Behaviour:
- Reset values, all forced asynchronously while SIM_RST is high, including mid-operation:
  - mem_e_n, mem_g_n, mem_w_n, mem_lb_n, mem_ub_n = 1.
  - mem_dq_oe = 0, mem_a = 0, mem_dq_out = 0.
  - ack = 0, busy = 0, rdata = 0, state = IDLE.
  - An interrupted write may leave MRAM content undefined. No ack is issued for it.
- Request capture: in IDLE with req=1, latch we/addr/wdata/be into registers. mem_a and byte selects come from these registers only.
- A 4-bit down-counter times every timed state. It is loaded with (param-1) on state entry, and the state exits when the counter reaches 0.
- States:
  - IDLE: all strobes high, oe=0. On req go to WSU (we=1) or RSU (we=0).
  - WSU: e_n=0, g_n=1, w_n=1, oe=1, lb_n/ub_n=~be. Lasts T_SU cycles, then WP.
  - WP: w_n=0; everything else as WSU. Lasts T_WP cycles, then WHD.
  - WHD: w_n=1, data and address still driven. Lasts T_HD cycles, then DONE.
  - RSU: e_n=0, g_n=1, oe=0. Lasts T_SU cycles, then RD.
  - RD: g_n=0. Lasts T_RD cycles. On the last cycle, rdata <= mem_dq_in, then DONE.
  - DONE: ack=1 for exactly one cycle, e_n=1, g_n=1, oe=0, then IDLE.
- Invariants, checked by assertions:
  - g_n=0 and w_n=0 never occur together.
  - oe=1 never occurs while g_n=0.
  - w_n=0 only while e_n=0.
  - mem_a and mem_dq_out never change while w_n=0.
- Bus turnaround: IDLE and DONE each give at least one cycle with oe=0 and g_n=1 between any two accesses.
- Back-to-back: req held high through DONE is accepted in the following IDLE cycle. Minimum spacing is 2 cycles plus the access duration.
- Latency (req cycle to ack cycle):
  - Write: 1 + T_SU + T_WP + T_HD cycles (defaults: 7).
  - Read: 1 + T_SU + T_RD cycles (defaults: 6).
- req while busy is ignored, not queued.
- Byte enables:
  - Apply to both reads and writes.
  - be=2'b00 still runs the full cycle with both selects high, and still acks.
  - rdata lanes whose select was deasserted hold their previous value.

Test Plan:
- Write then read, defaults: write addr=0x0123, wdata=0xBEEF, be=3 -> ack 7 cycles after req; read addr=0x0123 -> ack 6 cycles after req, rdata=0xBEEF.
- Strobe ordering: monitor the write waveform -> W_n low for exactly 3 cycles, G_n high throughout, mem_a and DQ stable while W_n is low; no cycle has G_n=0 with OE=1.
- Byte lanes: write 0x1234 (be=3), then 0xAB00 with be=2 to the same address; read with be=3 -> 0xAB34.
- Back-to-back with req held high: write 0x0005 to 0x0010, then immediately read 0x0010 -> read accepted on the first IDLE cycle after DONE, rdata=0x0005; OE low for at least 1 cycle between the two accesses.
- Reset mid-write: assert SIM_RST during WP -> in the same cycle W_n=1, E_n=1, OE=0, busy=0, no ack; after release, a read of addr 0 -> rdata=0x0000.
- Parameter sweep T_SU=1, T_WP=1, T_HD=1, T_RD=1: write/read 0xFFFF to 0x07FF -> write ack at cycle 4, read ack at cycle 3, data matches; req asserted while busy -> no extra ack.
